// File: rtl/mouse_packet_tracker.sv
// mouse_packet_tracker
// Decodes 3-byte PS/2 mouse packets coming from the byte receiver. Each packet's
// signed X/Y deltas are added to screen coordinates, and the result is clamped to
// 0..MAX_X and 0..MAX_Y. The block also reports button levels, click pulses and a
// per-packet event strobe.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous reset, active low
//   rx_data      byte from the PS/2 receiver
//   rx_valid     one-cycle strobe qualifying rx_data
//   setx, sety   load xpos / ypos from set_value (clamped to range)
//   set_value    load value
//   xpos, ypos   current position (ypos 0 = top of screen)
//   left, right, middle       button levels from the last packet
//   left_click, right_click   one-cycle pulse on a press
//   new_event    one-cycle pulse per processed packet
//   sync_err     one-cycle pulse on a framing error or an inter-byte timeout
//
// state   | meaning
// WAIT_B0 | idle, next byte must be a header (bit 3 set)
// WAIT_B1 | header held, waiting for the X delta byte
// WAIT_B2 | X byte held, waiting for the Y delta byte

module mouse_packet_tracker #(
    parameter int POS_W       = 12,
    parameter int MAX_X       = 799,
    parameter int MAX_Y       = 599,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    input  logic             setx,
    input  logic             sety,
    input  logic [POS_W-1:0] set_value,
    output logic [POS_W-1:0] xpos,
    output logic [POS_W-1:0] ypos,
    output logic             left,
    output logic             right,
    output logic             middle,
    output logic             left_click,
    output logic             right_click,
    output logic             new_event,
    output logic             sync_err
);

    localparam logic [1:0] WAIT_B0 = 2'd0;
    localparam logic [1:0] WAIT_B1 = 2'd1;
    localparam logic [1:0] WAIT_B2 = 2'd2;

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0]        TMO_LOAD = CNT_W'(TIMEOUT_CYC);
    localparam logic [POS_W-1:0]        MAX_X_P  = POS_W'(MAX_X);
    localparam logic [POS_W-1:0]        MAX_Y_P  = POS_W'(MAX_Y);
    localparam logic signed [POS_W+1:0] MAX_X_S  = (POS_W+2)'(MAX_X);
    localparam logic signed [POS_W+1:0] MAX_Y_S  = (POS_W+2)'(MAX_Y);

    logic [1:0]       state;
    logic [CNT_W-1:0] tmo_cnt;
    // Header bit 3 is always 1 in an accepted header, so it is not stored.
    // hdr = {YO, XO, YS, XS, M, R, L}
    logic [6:0]       hdr;
    logic [7:0]       b1;
    logic [7:0]       b2;
    logic             pending;

    logic                    expire;
    logic                    in_b0;
    logic                    take_b0;
    logic                    bad_b0;
    logic signed [8:0]       dx9;
    logic signed [8:0]       dy9;
    logic signed [POS_W+1:0] x_sum;
    logic signed [POS_W+1:0] y_sum;
    logic [POS_W-1:0]        x_upd;
    logic [POS_W-1:0]        y_upd;

    // An expiring packet and a byte arriving in the same cycle: the byte is
    // judged as a fresh header.
    assign expire  = ((state == WAIT_B1) || (state == WAIT_B2)) && (tmo_cnt == '0);
    assign in_b0   = !((state == WAIT_B1) || (state == WAIT_B2)) || expire;
    assign take_b0 = rx_valid && in_b0 && rx_data[3];
    assign bad_b0  = rx_valid && in_b0 && !rx_data[3];

    always_comb begin
        dx9   = hdr[5] ? 9'sd0 : $signed({hdr[3], b1});
        dy9   = hdr[6] ? 9'sd0 : $signed({hdr[4], b2});
        x_sum = $signed({2'b00, xpos}) + {{(POS_W-7){dx9[8]}}, dx9};
        // PS/2 Y grows upward and screen Y grows downward.
        y_sum = $signed({2'b00, ypos}) - {{(POS_W-7){dy9[8]}}, dy9};
        if (x_sum[POS_W+1])
            x_upd = '0;
        else if (x_sum > MAX_X_S)
            x_upd = MAX_X_P;
        else
            x_upd = x_sum[POS_W-1:0];
        if (y_sum[POS_W+1])
            y_upd = '0;
        else if (y_sum > MAX_Y_S)
            y_upd = MAX_Y_P;
        else
            y_upd = y_sum[POS_W-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= WAIT_B0;
            tmo_cnt  <= '0;
            hdr      <= '0;
            b1       <= '0;
            b2       <= '0;
            pending  <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            pending  <= 1'b0;
            sync_err <= expire || bad_b0;
            if (in_b0) begin
                if (take_b0) begin
                    hdr     <= {rx_data[7:4], rx_data[2:0]};
                    state   <= WAIT_B1;
                    tmo_cnt <= TMO_LOAD;
                end else begin
                    state   <= WAIT_B0;
                    tmo_cnt <= '0;
                end
            end else if (rx_valid) begin
                if (state == WAIT_B1) begin
                    b1      <= rx_data;
                    state   <= WAIT_B2;
                    tmo_cnt <= TMO_LOAD;
                end else begin
                    b2      <= rx_data;
                    pending <= 1'b1;
                    state   <= WAIT_B0;
                    tmo_cnt <= '0;
                end
            end else begin
                tmo_cnt <= tmo_cnt - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            xpos        <= '0;
            ypos        <= '0;
            left        <= 1'b0;
            right       <= 1'b0;
            middle      <= 1'b0;
            left_click  <= 1'b0;
            right_click <= 1'b0;
            new_event   <= 1'b0;
        end else begin
            left_click  <= 1'b0;
            right_click <= 1'b0;
            new_event   <= 1'b0;
            if (pending) begin
                left        <= hdr[0];
                right       <= hdr[1];
                middle      <= hdr[2];
                left_click  <= hdr[0] & ~left;
                right_click <= hdr[1] & ~right;
                new_event   <= 1'b1;
                xpos        <= x_upd;
                ypos        <= y_upd;
            end
            // A direct load overrides any packet motion on that axis.
            if (setx)
                xpos <= (set_value > MAX_X_P) ? MAX_X_P : set_value;
            if (sety)
                ypos <= (set_value > MAX_Y_P) ? MAX_Y_P : set_value;
        end
    end

endmodule

// File: tb/tb_mouse_packet_tracker.sv
module tb_mouse_packet_tracker;

    localparam int POS_W = 12;
    localparam int MAX_X = 799;
    localparam int MAX_Y = 599;
    localparam int TMO   = 50;

    logic             clk;
    logic             rst;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             setx;
    logic             sety;
    logic [POS_W-1:0] set_value;
    logic [POS_W-1:0] xpos;
    logic [POS_W-1:0] ypos;
    logic             left;
    logic             right;
    logic             middle;
    logic             left_click;
    logic             right_click;
    logic             new_event;
    logic             sync_err;

    int tests = 0;
    int fails = 0;
    int ne_cnt = 0;
    int lc_cnt = 0;
    int rc_cnt = 0;
    int se_cnt = 0;

    mouse_packet_tracker #(
        .POS_W(POS_W), .MAX_X(MAX_X), .MAX_Y(MAX_Y), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .setx(setx), .sety(sety), .set_value(set_value),
        .xpos(xpos), .ypos(ypos), .left(left), .right(right), .middle(middle),
        .left_click(left_click), .right_click(right_click),
        .new_event(new_event), .sync_err(sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters: a pulse held for N cycles is counted N times.
    always @(posedge clk) begin
        if (new_event)   ne_cnt <= ne_cnt + 1;
        if (left_click)  lc_cnt <= lc_cnt + 1;
        if (right_click) rc_cnt <= rc_cnt + 1;
        if (sync_err)    se_cnt <= se_cnt + 1;
    end

    task automatic clear_counts();
        ne_cnt = 0; lc_cnt = 0; rc_cnt = 0; se_cnt = 0;
    endtask

    // Called at a negedge, returns at a negedge with rx_valid low.
    task automatic send_bytes(input logic [7:0] b [], input int n);
        for (int i = 0; i < n; i++) begin
            rx_data  = b[i];
            rx_valid = 1'b1;
            @(negedge clk);
        end
        rx_valid = 1'b0;
    endtask

    task automatic send_packet(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        logic [7:0] v [];
        v = new[3];
        v[0] = a; v[1] = b; v[2] = c;
        clear_counts();
        send_bytes(v, 3);
        repeat (3) @(negedge clk);
    endtask

    task automatic load_axis(input logic is_x, input logic [POS_W-1:0] v);
        setx = is_x; sety = ~is_x; set_value = v;
        @(negedge clk);
        setx = 1'b0; sety = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (5) @(negedge clk);
        tests++;
        if ({xpos, ypos, left, right, middle, left_click, right_click, new_event, sync_err} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got x=%0d y=%0d pulses/levels nonzero, want all 0", xpos, ypos);
        end
        rst = 1'b1;
        clear_counts();
        repeat (20) @(negedge clk);
        tests++;
        if (ne_cnt + lc_cnt + rc_cnt + se_cnt != 0 || xpos !== 0 || ypos !== 0) begin
            fails++;
            $display("FAIL reset_idle: got pulses=%0d x=%0d y=%0d, want 0 0 0",
                     ne_cnt + lc_cnt + rc_cnt + se_cnt, xpos, ypos);
        end
    endtask

    task automatic test_basic();
        send_packet(8'h09, 8'h10, 8'h05);
        tests++;
        if (xpos !== 16 || ypos !== 0 || left !== 1'b1 || lc_cnt != 1 || ne_cnt != 1) begin
            fails++;
            $display("FAIL basic_first: got x=%0d y=%0d L=%b lc=%0d ne=%0d, want 16 0 1 1 1",
                     xpos, ypos, left, lc_cnt, ne_cnt);
        end
        send_packet(8'h09, 8'h10, 8'h05);
        tests++;
        if (xpos !== 32 || left !== 1'b1 || lc_cnt != 0 || ne_cnt != 1) begin
            fails++;
            $display("FAIL basic_repeat: got x=%0d L=%b lc=%0d ne=%0d, want 32 1 0 1",
                     xpos, left, lc_cnt, ne_cnt);
        end
    endtask

    task automatic test_y_motion();
        clear_counts();
        load_axis(1'b0, 12'd300);
        @(negedge clk);
        tests++;
        if (ypos !== 300 || ne_cnt != 0) begin
            fails++;
            $display("FAIL sety_load: got y=%0d ne=%0d, want 300 0", ypos, ne_cnt);
        end
        send_packet(8'h28, 8'h00, 8'hFB);
        tests++;
        if (ypos !== 305 || xpos !== 32 || left !== 1'b0) begin
            fails++;
            $display("FAIL y_down: got y=%0d x=%0d L=%b, want 305 32 0", ypos, xpos, left);
        end
        send_packet(8'h08, 8'h00, 8'h0A);
        tests++;
        if (ypos !== 295) begin
            fails++;
            $display("FAIL y_up: got y=%0d, want 295", ypos);
        end
    endtask

    task automatic test_clamp();
        load_axis(1'b1, 12'd795);
        tests++;
        if (xpos !== 795) begin
            fails++;
            $display("FAIL setx_795: got %0d, want 795", xpos);
        end
        send_packet(8'h08, 8'h0A, 8'h00);
        tests++;
        if (xpos !== 799) begin
            fails++;
            $display("FAIL clamp_high: got %0d, want 799", xpos);
        end
        send_packet(8'h18, 8'hF6, 8'h00);
        tests++;
        if (xpos !== 789) begin
            fails++;
            $display("FAIL neg_dx: got %0d, want 789", xpos);
        end
        send_packet(8'h48, 8'h7F, 8'h00);
        tests++;
        if (xpos !== 789 || ne_cnt != 1) begin
            fails++;
            $display("FAIL x_overflow: got x=%0d ne=%0d, want 789 1", xpos, ne_cnt);
        end
        load_axis(1'b1, 12'd4095);
        tests++;
        if (xpos !== 799) begin
            fails++;
            $display("FAIL setx_clamp: got %0d, want 799", xpos);
        end
        load_axis(1'b0, 12'd4095);
        tests++;
        if (ypos !== 599) begin
            fails++;
            $display("FAIL sety_clamp: got %0d, want 599", ypos);
        end
    endtask

    task automatic test_framing();
        logic [7:0] v [];
        v = new[1];
        v[0] = 8'h00;
        load_axis(1'b1, 12'd500);
        clear_counts();
        send_bytes(v, 1);
        repeat (3) @(negedge clk);
        tests++;
        if (se_cnt != 1 || ne_cnt != 0) begin
            fails++;
            $display("FAIL framing_err: got se=%0d ne=%0d, want 1 0", se_cnt, ne_cnt);
        end
        send_packet(8'h0A, 8'h01, 8'h00);
        tests++;
        if (right !== 1'b1 || rc_cnt != 1 || xpos !== 501 || left !== 1'b0 || se_cnt != 0) begin
            fails++;
            $display("FAIL framing_resync: got R=%b rc=%0d x=%0d L=%b se=%0d, want 1 1 501 0 0",
                     right, rc_cnt, xpos, left, se_cnt);
        end
    endtask

    task automatic test_timeout();
        logic [7:0] v [];
        int cyc;
        v = new[2];
        v[0] = 8'h08; v[1] = 8'h05;
        clear_counts();
        send_bytes(v, 2);
        cyc = 0;
        while (!sync_err && cyc < 3 * TMO) begin
            @(negedge clk);
            cyc++;
        end
        tests++;
        if (cyc != TMO + 1) begin
            fails++;
            $display("FAIL timeout_latency: got %0d cycles, want %0d", cyc, TMO + 1);
        end
        repeat (3) @(negedge clk);
        tests++;
        if (se_cnt != 1 || ne_cnt != 0 || xpos !== 501) begin
            fails++;
            $display("FAIL timeout_discard: got se=%0d ne=%0d x=%0d, want 1 0 501", se_cnt, ne_cnt, xpos);
        end
        send_packet(8'h08, 8'h01, 8'h00);
        tests++;
        if (xpos !== 502 || right !== 1'b0 || rc_cnt != 0) begin
            fails++;
            $display("FAIL timeout_resync: got x=%0d R=%b rc=%0d, want 502 0 0", xpos, right, rc_cnt);
        end
    endtask

    task automatic test_collision();
        logic [7:0] v [];
        v = new[3];
        v[0] = 8'h08; v[1] = 8'h03; v[2] = 8'h00;
        clear_counts();
        send_bytes(v, 3);
        // This cycle is the update cycle for the packet.
        setx = 1'b1; set_value = 12'd100;
        @(negedge clk);
        setx = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if (xpos !== 100 || ne_cnt != 1) begin
            fails++;
            $display("FAIL set_collision: got x=%0d ne=%0d, want 100 1", xpos, ne_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] v [];
        v = new[6];
        v[0] = 8'h08; v[1] = 8'h05; v[2] = 8'h00;
        v[3] = 8'h08; v[4] = 8'h05; v[5] = 8'h00;
        clear_counts();
        send_bytes(v, 6);
        repeat (3) @(negedge clk);
        tests++;
        if (xpos !== 110 || ne_cnt != 2 || se_cnt != 0) begin
            fails++;
            $display("FAIL back_to_back: got x=%0d ne=%0d se=%0d, want 110 2 0", xpos, ne_cnt, se_cnt);
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] v [];
        v = new[2];
        v[0] = 8'h08; v[1] = 8'h10;
        send_bytes(v, 2);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if (xpos !== 0 || ypos !== 0 || new_event !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset: got x=%0d y=%0d ne=%b, want 0 0 0", xpos, ypos, new_event);
        end
        rst = 1'b1;
        @(negedge clk);
        // A byte without bit 3 is only a framing error if the FSM is back in WAIT_B0.
        v = new[1];
        v[0] = 8'h01;
        clear_counts();
        send_bytes(v, 1);
        repeat (3) @(negedge clk);
        tests++;
        if (se_cnt != 1 || ne_cnt != 0 || xpos !== 0) begin
            fails++;
            $display("FAIL mid_reset_resync: got se=%0d ne=%0d x=%0d, want 1 0 0", se_cnt, ne_cnt, xpos);
        end
    endtask

    initial begin
        rst = 1'b0; rx_data = '0; rx_valid = 1'b0;
        setx = 1'b0; sety = 1'b0; set_value = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_y_motion();
        test_clamp();
        test_framing();
        test_timeout();
        test_collision();
        test_back_to_back();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mouse_packet_tracker.md
Name: mouse_packet_tracker

Overview:
Parametrised PS/2 mouse packet decoder and position tracker. It sits between the PS/2 byte receiver and the frequency-meter UI logic.
- Assembles standard 3-byte mouse packets and accumulates signed X/Y deltas into clamped screen coordinates of configurable width and range.
- Reports button levels, one-cycle click pulses and per-packet event strobes.
- Resynchronises on framing errors and inter-byte timeouts.

Parameters:
POS_W, 12, width of xpos/ypos/set_value
MAX_X, 799, upper clamp for xpos (must be < 2**POS_W)
MAX_Y, 599, upper clamp for ypos (must be < 2**POS_W)
TIMEOUT_CYC, 100000, max idle cycles between bytes of one packet before discard

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
rx_data  in  8  byte from PS/2 receiver
rx_valid  in  1  one-cycle strobe, rx_data valid
setx  in  1  load xpos from set_value
sety  in  1  load ypos from set_value
set_value  in  POS_W  load value for setx/sety
xpos  out  POS_W  X position, 0..MAX_X
ypos  out  POS_W  Y position, 0..MAX_Y, 0 = top
left  out  1  left button level
right  out  1  right button level
middle  out  1  middle button level
left_click  out  1  one-cycle pulse on left press
right_click  out  1  one-cycle pulse on right press
new_event  out  1  one-cycle pulse per processed packet
sync_err  out  1  one-cycle pulse on framing error or timeout

Behaviour:
- Reset (rst=0, async):
  - All outputs 0.
  - FSM in WAIT_B0.
  - Timeout counter, byte registers and pending flag cleared.
- FSM states and transitions:
  - WAIT_B0: on rx_valid, if rx_data[3]=1, store b0 and go to WAIT_B1. Otherwise drop the byte, pulse sync_err next cycle, stay in WAIT_B0.
  - WAIT_B1: on rx_valid, store b1 and go to WAIT_B2.
  - WAIT_B2: on rx_valid, store b2, set pending, go to WAIT_B0.
- Byte 0 fields: [0] L, [1] R, [2] M, [4] X sign, [5] Y sign, [6] X overflow, [7] Y overflow.
- Deltas:
  - dx = signed 9-bit {b0[4], b1}; dy = signed 9-bit {b0[5], b2}.
  - If the axis overflow bit is set, that axis delta is forced to 0.
- Update cycle (pending=1), i.e. the edge after b2 is captured, giving outputs 2 edges after the b2 strobe edge:
  - xpos <= clamp(xpos + dx, 0, MAX_X).
  - ypos <= clamp(ypos - dy, 0, MAX_Y). PS/2 Y is positive up, so it is inverted.
  - Arithmetic is signed, POS_W+2 bits, with no wrap-around.
  - left/right/middle <= b0[0]/b0[1]/b0[2].
  - left_click = b0[0] & ~left (old value); right_click likewise.
  - new_event = 1 for that cycle.
  - pending clears.
- setx/sety:
  - Loads min(set_value, MAX_X) or min(set_value, MAX_Y) on the next edge.
  - If coincident with the update cycle, the load wins for that axis and that axis' packet delta is discarded.
  - The other axis, buttons and new_event proceed normally.
  - setx/sety never generate new_event.
- Timeout:
  - Counter resets on every accepted byte and counts while in WAIT_B1 or WAIT_B2.
  - On reaching TIMEOUT_CYC, the FSM goes to WAIT_B0, the partial packet is discarded and sync_err pulses.
  - A byte arriving in the same cycle as the expiry is evaluated as byte 0.
- The counter is held at 0 in WAIT_B0.
- rx_valid arriving during the pending cycle is accepted normally as the next packet's byte 0.
- Pulse outputs (left_click, right_click, new_event, sync_err) are exactly one cycle wide and registered.
- Reset asserted mid-packet aborts immediately; no partial update occurs.

Test Plan:
1. Reset: hold rst=0 for 5 cycles, then release -> all outputs 0, no pulses for 20 idle cycles.
2. Basic packet: bytes 0x09, 0x10, 0x05 -> left=1, left_click and new_event each pulse once, xpos=16, ypos=0 (clamped from -5). Repeat the same packet -> no left_click, xpos=32.
3. Y motion and set: sety with set_value=300, then packet 0x28, 0x00, 0xFB (dy=-5) -> ypos=305. Packet 0x08, 0x00, 0x0A -> ypos=295.
4. Clamp and overflow:
   - setx=795, packet 0x08, 0x0A, 0x00 -> xpos=799.
   - Packet 0x18, 0xF6, 0x00 -> xpos=789.
   - Packet 0x48, 0x7F, 0x00 -> xpos unchanged, new_event pulses.
   - setx=4095 -> xpos=799.
5. Framing: byte 0x00 in WAIT_B0 -> sync_err pulse, no new_event. Then 0x0A, 0x01, 0x00 -> right=1, right_click pulse, xpos+1.
6. Timeout/collision:
   - Send 0x08, 0x05, then idle TIMEOUT_CYC cycles -> sync_err pulse.
   - Then 0x08, 0x01, 0x00 -> xpos+1 (not +5).
   - Separately, assert setx=100 on the update cycle of a dx=+3 packet -> xpos=100, new_event still pulses.
